// File: rtl/router_sched_pkg.sv
// router_sched_pkg: shared op codes, FSM states, router select encodings and the
// router/adder control word for router_sched.
// Optional feature macro: ROUTER_SCHED_ABS_EN (op 110 = ABS when defined, reserved otherwise).
package router_sched_pkg;

    localparam int NREQ = 2;
    localparam int OPW  = 3;

    localparam logic [OPW-1:0] OP_ADD    = 3'd0;
    localparam logic [OPW-1:0] OP_SUB    = 3'd1;
    localparam logic [OPW-1:0] OP_NEG    = 3'd2;
    localparam logic [OPW-1:0] OP_MOVA   = 3'd3;
    localparam logic [OPW-1:0] OP_ACC    = 3'd4;
    localparam logic [OPW-1:0] OP_ACCSUB = 3'd5;
    localparam logic [OPW-1:0] OP_ABS    = 3'd6;
    localparam logic [OPW-1:0] OP_RSVD   = 3'd7;

    localparam logic [1:0] SELR_A    = 2'b00;
    localparam logic [1:0] SELR_RQ   = 2'b01;
    localparam logic [1:0] SELR_ZERO = 2'b10;
    localparam logic [1:0] SELR_ONES = 2'b11;
    localparam logic [1:0] SELS_B    = 2'b00;
    localparam logic [1:0] SELS_RD   = 2'b01;
    localparam logic [1:0] SELS_ZERO = 2'b10;
    localparam logic [1:0] SELS_ONES = 2'b11;
    localparam logic [1:0] SELI_ZERO = 2'b00;
    localparam logic [1:0] SELI_ONE  = 2'b01;
    localparam logic [1:0] SELI_ONES = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
`ifdef ROUTER_SCHED_ABS_EN
        ST_CHK,
        ST_FIX,
`endif
        ST_RSP
    } state_t;

    typedef struct packed {
        logic [1:0] sel_R;
        logic [1:0] sel_S;
        logic       inv_R;
        logic       inv_S;
        logic [1:0] sel_I;
        logic       ld_RQ;
    } cw_t;

    localparam cw_t CW_IDLE = '{SELR_ZERO, SELS_ZERO, 1'b0, 1'b0, SELI_ZERO, 1'b0};
`ifdef ROUTER_SCHED_ABS_EN
    localparam cw_t CW_CHK  = '{SELR_RQ, SELS_ZERO, 1'b0, 1'b0, SELI_ZERO, 1'b0};
    localparam cw_t CW_FIX  = '{SELR_RQ, SELS_ZERO, 1'b1, 1'b0, SELI_ONE, 1'b1};
`endif

    // Control word of the EXEC step; reserved ops fall through to the idle word.
    function automatic cw_t exec_cw(input logic [OPW-1:0] op);
        cw_t c;
        c = CW_IDLE;
        case (op)
            OP_ADD:    c = '{SELR_A,  SELS_B,    1'b0, 1'b0, SELI_ZERO, 1'b1};
            OP_SUB:    c = '{SELR_A,  SELS_B,    1'b0, 1'b1, SELI_ONE,  1'b1};
            OP_NEG:    c = '{SELR_A,  SELS_ZERO, 1'b1, 1'b0, SELI_ONE,  1'b1};
            OP_MOVA:   c = '{SELR_A,  SELS_ZERO, 1'b0, 1'b0, SELI_ZERO, 1'b1};
            OP_ACC:    c = '{SELR_RQ, SELS_B,    1'b0, 1'b0, SELI_ZERO, 1'b1};
            OP_ACCSUB: c = '{SELR_RQ, SELS_B,    1'b0, 1'b1, SELI_ONE,  1'b1};
`ifdef ROUTER_SCHED_ABS_EN
            OP_ABS:    c = '{SELR_A,  SELS_ZERO, 1'b0, 1'b0, SELI_ZERO, 1'b1};
`endif
            default:   c = CW_IDLE;
        endcase
        return c;
    endfunction

    // Every legal op loads RQ in EXEC, so a missing load marks a reserved op.
    function automatic logic is_rsvd(input logic [OPW-1:0] op);
        cw_t c;
        c = exec_cw(op);
        return !c.ld_RQ;
    endfunction

endpackage

// File: rtl/router_sched_if.sv
// router_sched_if: request/response and router control bundle of router_sched.
// slave  : the scheduler (takes requests and msb_R, drives grants, router controls, responses).
// master : the requester/router side (drives requests and msb_R).
interface router_sched_if;
    import router_sched_pkg::*;

    logic [NREQ-1:0] req_valid;
    logic [OPW-1:0]  req_op0;
    logic [OPW-1:0]  req_op1;
    logic [NREQ-1:0] req_ready;
    logic            gnt_id;
    logic            msb_R;
    logic [1:0]      sel_R;
    logic [1:0]      sel_S;
    logic            inv_R;
    logic            inv_S;
    logic [1:0]      sel_I;
    logic            ld_RQ;
    logic            rsp_valid;
    logic            rsp_id;
    logic            rsp_err;
    logic            busy;

    modport slave (
        input  req_valid, req_op0, req_op1, msb_R,
        output req_ready, gnt_id, sel_R, sel_S, inv_R, inv_S, sel_I, ld_RQ,
               rsp_valid, rsp_id, rsp_err, busy
    );

    modport master (
        output req_valid, req_op0, req_op1, msb_R,
        input  req_ready, gnt_id, sel_R, sel_S, inv_R, inv_S, sel_I, ld_RQ,
               rsp_valid, rsp_id, rsp_err, busy
    );

endinterface

// File: rtl/router_sched_rr_arb2.sv
// rr_arb2: two-port round-robin arbiter with a last-grant pointer.
// Ports: clk, rst_n (async active-low), i_req (per-port request), i_upd/i_upd_id
// (record a completed grant and its winner), o_gnt (combinational one-hot pick).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic [1:0] o_gnt
);

    logic r_last;

    // Reset as if port 1 won last so port 0 is favoured first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_last <= 1'b1;
        else if (i_upd) r_last <= i_upd_id;
    end

    assign o_gnt = (&i_req) ? (r_last ? 2'b01 : 2'b10) : i_req;

endmodule

// File: rtl/router_sched.sv
// router_sched: two-port arbiter and step sequencer driving the router_b operand
// router and adder (sel_R/sel_S/inv_R/inv_S/sel_I/ld_RQ), with a response per op.
// Ports: clk, rst_n (async active-low), bus (router_sched_if.slave).
// Macro ROUTER_SCHED_ABS_EN enables the multi-step ABS op (110).
module router_sched
    import router_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    router_sched_if.slave bus
);

    state_t         r_state, w_state_nxt;
    logic [OPW-1:0] r_op, w_op_nxt;
    cw_t            r_cw, w_cw;
    logic [1:0]     r_ready, w_arb;
    logic           r_gnt_id, r_rsp_valid, r_rsp_id, r_rsp_err, r_busy;
    logic           w_hs, w_id;

    // req_ready is registered, so the handshake completes only if the offered
    // port still holds valid in the ready cycle.
    assign w_hs     = |(bus.req_valid & r_ready);
    assign w_id     = r_ready[1];
    assign w_op_nxt = w_hs ? (w_id ? bus.req_op1 : bus.req_op0) : r_op;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (bus.req_valid),
        .i_upd    (w_hs),
        .i_upd_id (w_id),
        .o_gnt    (w_arb)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_hs ? ST_EXEC : ST_IDLE;
`ifdef ROUTER_SCHED_ABS_EN
            ST_EXEC: w_state_nxt = (r_op == OP_ABS) ? ST_CHK : ST_RSP;
            ST_CHK:  w_state_nxt = bus.msb_R ? ST_FIX : ST_RSP;
            ST_FIX:  w_state_nxt = ST_RSP;
`else
            ST_EXEC: w_state_nxt = ST_RSP;
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered, so the word is chosen for the state being entered.
    always_comb begin
        w_cw = CW_IDLE;
        case (w_state_nxt)
            ST_EXEC: w_cw = exec_cw(w_op_nxt);
`ifdef ROUTER_SCHED_ABS_EN
            ST_CHK:  w_cw = CW_CHK;
            ST_FIX:  w_cw = CW_FIX;
`endif
            default: w_cw = CW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_cw        <= CW_IDLE;
            r_ready     <= 2'b00;
            r_gnt_id    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_cw        <= w_cw;
            r_ready     <= (w_state_nxt == ST_IDLE && r_ready == 2'b00) ? w_arb : 2'b00;
            r_gnt_id    <= w_hs ? w_id : r_gnt_id;
            r_rsp_valid <= w_state_nxt == ST_RSP;
            r_rsp_id    <= (w_state_nxt == ST_RSP) ? r_gnt_id : r_rsp_id;
            r_rsp_err   <= (w_state_nxt == ST_RSP) && is_rsvd(r_op);
            r_busy      <= w_state_nxt != ST_IDLE;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.sel_R     = r_cw.sel_R;
    assign bus.sel_S     = r_cw.sel_S;
    assign bus.inv_R     = r_cw.inv_R;
    assign bus.inv_S     = r_cw.inv_S;
    assign bus.sel_I     = r_cw.sel_I;
    assign bus.ld_RQ     = r_cw.ld_RQ;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_router_sched.sv
// tb_router_sched: directed self-checking bench for router_sched.
// Control words are compared as {sel_R, sel_S, inv_R, inv_S, sel_I, ld_RQ}.
// The ABS checks follow ROUTER_SCHED_ABS_EN, matching the RTL build.
module tb_router_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    router_sched_if bus ();

    router_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] CW_IDLE_E = 9'b10_10_0_0_00_0;
    localparam logic [8:0] CW_ADD_E  = 9'b00_00_0_0_00_1;
    localparam logic [8:0] CW_SUB_E  = 9'b00_00_0_1_01_1;
    localparam logic [8:0] CW_NEG_E  = 9'b00_10_1_0_01_1;
    localparam logic [8:0] CW_MOVA_E = 9'b00_10_0_0_00_1;
    localparam logic [8:0] CW_ACC_E  = 9'b01_00_0_0_00_1;
    localparam logic [8:0] CW_ACCS_E = 9'b01_00_0_1_01_1;
    localparam logic [8:0] CW_CHK_E  = 9'b01_10_0_0_00_0;
    localparam logic [8:0] CW_FIX_E  = 9'b01_10_1_0_01_1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] cw();
        return {bus.sel_R, bus.sel_S, bus.inv_R, bus.inv_S, bus.sel_I, bus.ld_RQ};
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cw"}, 32'(cw()), 32'(CW_IDLE_E));
        chk({tag, "_outs"}, {26'd0, bus.req_ready, bus.gnt_id, bus.rsp_valid, bus.rsp_id,
                             bus.rsp_err, bus.busy}, 32'd0);
    endtask

    // Raise a request and wait (bounded) for its ready pulse; returns just after
    // the closing edge of the grant cycle, i.e. early in EXEC.
    task automatic grant(input int p, input logic [2:0] op);
        int n;
        if (p == 0) bus.req_op0 = op;
        else bus.req_op1 = op;
        bus.req_valid[p] = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.req_ready[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_ready", 32'(bus.req_ready), (p == 0) ? 32'd1 : 32'd2);
        @(posedge clk);
        #1 bus.req_valid[p] = 1'b0;
    endtask

    task automatic run_single(input int p, input logic [2:0] op, input logic [8:0] exp_cw,
                              input logic exp_err);
        grant(p, op);
        @(negedge clk);
        chk("exec_cw", 32'(cw()), 32'(exp_cw));
        chk("exec_busy_gnt", {30'd0, bus.busy, bus.gnt_id}, {30'd0, 1'b1, 1'(p)});
        chk("exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp", {29'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_err}, {29'd0, 1'b1, 1'(p), exp_err});
        chk("rsp_cw", 32'(cw()), 32'(CW_IDLE_E));
        @(negedge clk);
        chk("after_rsp", {30'd0, bus.rsp_valid, bus.busy}, 32'd0);
    endtask

`ifdef ROUTER_SCHED_ABS_EN
    task automatic run_abs(input logic neg);
        bus.msb_R = neg;
        grant(0, 3'b110);
        @(negedge clk);
        chk("abs_exec_cw", 32'(cw()), 32'(CW_MOVA_E));
        @(negedge clk);
        chk("abs_chk_cw", 32'(cw()), 32'(CW_CHK_E));
        chk("abs_chk_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        if (neg) begin
            chk("abs_fix_cw", 32'(cw()), 32'(CW_FIX_E));
            chk("abs_fix_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        chk("abs_rsp", {29'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_err}, 32'b100);
        chk("abs_rsp_cw", 32'(cw()), 32'(CW_IDLE_E));
        bus.msb_R = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        int g, r, cyc, last_rsp;
        logic cur;
        bus.req_valid = 2'b00;
        bus.req_op0 = 3'd0;
        bus.req_op1 = 3'd0;
        bus.msb_R = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("post_reset_idle");

        // Basic SUB from port 0, then every single-step op from port 1.
        run_single(0, 3'b001, CW_SUB_E, 1'b0);
        run_single(1, 3'b000, CW_ADD_E, 1'b0);
        run_single(1, 3'b001, CW_SUB_E, 1'b0);
        run_single(1, 3'b010, CW_NEG_E, 1'b0);
        run_single(1, 3'b011, CW_MOVA_E, 1'b0);
        run_single(1, 3'b100, CW_ACC_E, 1'b0);
        run_single(1, 3'b101, CW_ACCS_E, 1'b0);
        run_single(1, 3'b111, CW_IDLE_E, 1'b1);

        // Both ports hold ADD: last winner was port 1, so grants go 0,1,0,1.
        bus.req_op0 = 3'd0;
        bus.req_op1 = 3'd0;
        bus.req_valid = 2'b11;
        g = 0; r = 0; cyc = 0; last_rsp = -1; cur = 1'b0;
        while (r < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != 2'b00) begin
                chk("alt_grant", 32'(bus.req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
                cur = bus.req_ready[1];
                g++;
            end
            if (bus.busy) chk("alt_gnt_hold", 32'(bus.gnt_id), 32'(cur));
            if (bus.rsp_valid) begin
                chk("alt_rsp_id", 32'(bus.rsp_id), 32'(cur));
                if (last_rsp >= 0) chk("alt_rsp_gap", 32'(cyc - last_rsp), 32'd3);
                last_rsp = cyc;
                r++;
            end
        end
        bus.req_valid = 2'b00;
        chk("alt_rsp_count", 32'(r), 32'd4);
        repeat (2) @(negedge clk);

`ifdef ROUTER_SCHED_ABS_EN
        run_abs(1'b1);
        run_abs(1'b0);
`else
        run_single(0, 3'b110, CW_IDLE_E, 1'b1);
`endif

        // Reset mid-op (CHK with ABS, EXEC otherwise) after a port-0 win.
`ifdef ROUTER_SCHED_ABS_EN
        grant(0, 3'b110);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_chk_cw", 32'(cw()), 32'(CW_CHK_E));
`else
        grant(0, 3'b000);
        @(negedge clk);
        chk("pre_rst_exec_cw", 32'(cw()), 32'(CW_ADD_E));
`endif
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {30'd0, bus.rsp_valid, bus.busy}, 32'd0);
        end
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_favours_p0", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
